// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_entry_t : one fetched instruction and the byte address it came from
//   INSTR_BYTES   : PC increment per sequential fetch
//   NOP_INSTR     : word shown on if_instr when the fetch queue is empty
package fetch_pkg;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetch entries between the PC stage and decode.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   push          : write push_entry at the tail (ignored when full without pop)
//   push_entry    : entry to write
//   pop           : remove the head (ignored when empty)
//   flush         : discard all entries; takes priority over push and pop
//   head_entry    : current head entry (meaningful only when !empty)
//   full, empty   : occupancy flags
//   count         : number of valid entries
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int FQ_DEPTH = 2,
  localparam int PTR_W    = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1,
  localparam int CNT_W    = $clog2(FQ_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  input  logic               flush,
  output fetch_entry_t       head_entry,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t     mem [FQ_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             wr_en;
  logic             rd_en;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (cnt == CNT_W'(FQ_DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  assign rd_en = pop && !empty && !flush;
  assign wr_en = push && rst_n && !flush && (!full || rd_en);

  assign head_entry = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= next_ptr(wr_ptr);
      if (rd_en) rd_ptr <= next_ptr(rd_ptr);
      unique case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, combinational instruction-memory
// interface, and a fetch queue toward decode with redirect flushing.
// Optional build macro: FETCH_PERF_CNT_EN adds perf_fetched / perf_stalls.
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   PC_Value                    : fetch byte address to instruction memory
//   Instruction                 : memory read data for PC_Value (same cycle)
//   redirect_valid, redirect_pc : branch/jump redirect request and target
//   if_valid, if_ready          : handshake toward decode
//   if_instr, if_pc             : head instruction word and its address
//   perf_fetched, perf_stalls   : (FETCH_PERF_CNT_EN) push count, stall cycles
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] PC_Value,
  input  logic [31:0] Instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls
`endif
);

  localparam int CNT_W = $clog2(FQ_DEPTH + 1);

  logic [31:0]      pc_p0;
  logic             push;
  logic             pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;
  logic             fq_full;
  logic             fq_empty;
  logic [CNT_W-1:0] fq_count;

  assign PC_Value = pc_p0;

  assign pop  = if_valid && if_ready;
  // A pop frees a slot in the same cycle, so a full queue still streams.
  assign push = rst_n && !redirect_valid && (!fq_full || pop);

  assign push_entry.pc    = pc_p0;
  assign push_entry.instr = Instruction;

  // ---- stage p0: PC register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_p0 <= {RESET_PC[31:2], 2'b00};
    end else if (redirect_valid) begin
      pc_p0 <= {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      pc_p0 <= pc_p0 + 32'(INSTR_BYTES);
    end
  end

  // ---- stage p1: fetch queue toward decode ----
  // A redirect flushes whatever survives the same-cycle pop; the popped
  // head is still a completed transfer.
  fetch_queue #(
    .FQ_DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head_entry (head_entry),
    .full       (fq_full),
    .empty      (fq_empty),
    .count      (fq_count)
  );

  assign if_valid = (fq_count != '0);
  // Empty queue shows a NOP at the current PC (RESET_PC right after reset).
  assign if_instr = fq_empty ? NOP_INSTR : head_entry.instr;
  assign if_pc    = fq_empty ? pc_p0     : head_entry.pc;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stalls  <= '0;
    end else begin
      if (push)                 perf_fetched <= perf_fetched + 32'd1;
      if (if_valid && !if_ready) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a queue-based reference model predicts
// each cycle's outputs and every completed transfer; a negedge monitor
// compares the DUT against those predictions.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] PC_Value;
  logic [31:0] Instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;
`endif

  fetch_unit #(.RESET_PC(RPC), .FQ_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PC_Value       (PC_Value),
    .Instruction    (Instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stalls    (perf_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: an arbitrary but deterministic word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a ^ 32'h5A5A_0000) * 32'h0001_0003) + 32'h0000_0013;
  endfunction

  assign Instruction = mem_word(PC_Value);

  typedef struct {
    logic         valid;
    logic [31:0]  pc_value;
    fetch_entry_t head;
    logic         after_rst;
    logic [31:0]  pf;
    logic [31:0]  ps;
  } cyc_t;

  cyc_t         cyc_q[$];
  fetch_entry_t xfer_q[$];

  // Reference model state (what the unit holds after the latest edge).
  fetch_entry_t mq[$];
  logic [31:0]  mpc;
  logic [31:0]  mfetched;
  logic [31:0]  mstalls;
  logic         prev_rst_low;

  int checks;
  int passes;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // One cycle: drive inputs, record expectations, advance the model.
  task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rp);
    cyc_t         c;
    fetch_entry_t e;
    @(posedge clk);
    #1;
    rst_n          = r;
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;

    c.valid     = (mq.size() > 0);
    c.pc_value  = mpc;
    c.head      = c.valid ? mq[0] : '0;
    c.after_rst = prev_rst_low;
    c.pf        = mfetched;
    c.ps        = mstalls;
    cyc_q.push_back(c);
    if (c.valid && rdy) xfer_q.push_back(mq[0]);

    if (!r) begin
      mpc      = RPC;
      mq.delete();
      mfetched = '0;
      mstalls  = '0;
    end else begin
      if (c.valid && !rdy) mstalls = mstalls + 32'd1;
      if (c.valid && rdy) void'(mq.pop_front());
      if (rv) begin
        mpc = {rp[31:2], 2'b00};
        mq.delete();
      end else if (mq.size() < DEPTH) begin
        e.pc     = mpc;
        e.instr  = mem_word(mpc);
        mq.push_back(e);
        mpc      = mpc + 32'd4;
        mfetched = mfetched + 32'd1;
      end
    end
    prev_rst_low = !r;
  endtask

  // Monitor: one expectation record per cycle once stimulus has started.
  always @(negedge clk) begin
    cyc_t         c;
    fetch_entry_t e;
    if (cyc_q.size() > 0) begin
      c = cyc_q.pop_front();
      chk("if_valid", {31'b0, if_valid}, {31'b0, c.valid});
      chk("PC_Value", PC_Value, c.pc_value);
      if (c.valid) begin
        chk("if_pc", if_pc, c.head.pc);
        chk("if_instr", if_instr, c.head.instr);
      end else if (c.after_rst) begin
        chk("rst_if_pc", if_pc, RPC);
        chk("rst_if_instr", if_instr, NOP_INSTR);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, c.pf);
      chk("perf_stalls", perf_stalls, c.ps);
`endif
      if (if_valid && if_ready) begin
        if (xfer_q.size() == 0) begin
          checks++;
          $display("FAIL xfer: got unexpected transfer pc %h expected none", if_pc);
        end else begin
          e = xfer_q.pop_front();
          chk("xfer_pc", if_pc, e.pc);
          chk("xfer_instr", if_instr, e.instr);
        end
      end
    end
  end

  initial begin
    checks         = 0;
    passes         = 0;
    rst_n          = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mpc            = RPC;
    mfetched       = '0;
    mstalls        = '0;
    prev_rst_low   = 1'b1;
    repeat (2) @(posedge clk);

    // Reset, then free-running fetch from RESET_PC.
    step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Decode stalls five cycles right after reset, then releases.
    step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Unaligned redirect target.
    step(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Fill the queue, then redirect together with a pop.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0);

    // PC wrap-around.
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Back-to-back redirects.
    step(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0080);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Mid-stream reset coinciding with a redirect.
    step(1'b0, 1'b1, 1'b1, 32'h0000_0300);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0),
           rp);
    end

    @(negedge clk);
    #1;
    chk("xfer_q_drained", 32'(xfer_q.size()), 32'd0);
    chk("cyc_q_drained", 32'(cyc_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter FQ_DEPTH, default 2, fetch-queue entries; legal values 2..8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 PC_Value  output  32  byte address driven to instruction memory.
REQ-006 Instruction  input  32  combinational instruction-memory read data for PC_Value, same cycle.
REQ-007 redirect_valid  input  1  branch/jump redirect request.
REQ-008 redirect_pc  input  32  redirect target byte address.
REQ-009 if_valid  output  1  fetch queue head valid toward decode.
REQ-010 if_ready  input  1  decode accepts head this cycle.
REQ-011 if_instr  output  32  head instruction word.
REQ-012 if_pc  output  32  head instruction byte address.

Function
REQ-013 PC register drives PC_Value directly; bits [1:0] always 2'b00.
REQ-014 Push: when not redirecting and (queue not full or a pop occurs this cycle), {PC_Value, Instruction} is written to the queue tail and PC advances by 4 at the edge.
REQ-015 No push and PC held when queue full and no pop this cycle.
REQ-016 Pop: if_valid && if_ready removes head at the edge; if_valid deasserts only when queue empty.
REQ-017 if_instr/if_pc hold stable while if_valid && !if_ready.
REQ-018 Queue is strictly FIFO; simultaneous push and pop at full keeps count at FQ_DEPTH.
REQ-019 Redirect has priority over push: in a cycle with redirect_valid=1, PC loads {redirect_pc[31:2],2'b00}, no push occurs, and all entries remaining after any same-cycle pop are discarded.
REQ-020 A pop completing in a redirect cycle is a valid transfer; squashing it is decode's responsibility.
REQ-021 Redirect latency: redirect at cycle N -> if_valid=0 at N+1 -> target instruction presented at N+2.
REQ-022 Back-to-back redirects: last one wins; each flushes.
REQ-023 PC wrap-around: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
REQ-024 Steady state with if_ready=1: one instruction per cycle, no bubbles.

Reset
REQ-025 While rst_n=0 at an edge: PC=RESET_PC, queue empty, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=RESET_PC, no push.
REQ-026 Reset asserted mid-operation discards all queued entries and overrides redirect.
REQ-027 First instruction (at RESET_PC) visible with if_valid=1 one cycle after first edge with rst_n=1.

Configuration
REQ-028 Macro FETCH_PERF_CNT_EN defined: adds outputs perf_fetched (32, count of pushes) and perf_stalls (32, cycles with if_valid && !if_ready), both reset to 0, wrap silently.
REQ-029 Macro FETCH_PERF_CNT_EN undefined: those ports and counters do not exist; all other behaviour identical.

Structure
REQ-030 Package fetch_pkg holds fetch_entry_t {pc[31:0], instr[31:0]}, INSTR_BYTES=4, NOP_INSTR=32'h0000_0013.
REQ-031 Sub-module fetch_queue (parameterised FIFO of fetch_entry_t with push, pop, flush, full, empty, count) instantiated once.

Verification
REQ-032 Reset release, RESET_PC=0, if_ready=1 -> if_pc 0,4,8,12 on consecutive cycles, if_instr = memory words 0..3.
REQ-033 if_ready=0 for 5 cycles, FQ_DEPTH=2 -> PC_Value stops at 8, if_pc holds 0; on release if_pc 0,4,8 with no gap.
REQ-034 Redirect to 32'h0000_0103 at cycle N -> if_valid=0 at N+1, if_pc=32'h0000_0100 at N+2.
REQ-035 Redirect and pop together with queue full -> popped entry delivered, other entry discarded, next if_pc = target.
REQ-036 Redirect to 32'hFFFF_FFFC, if_ready=1 -> if_pc FFFF_FFFC then 0000_0000.
REQ-037 rst_n low for one cycle mid-stream with FETCH_PERF_CNT_EN defined -> if_valid=0, counters 0, fetch restarts at RESET_PC.
